// File: rtl/cabac_sao_bin_serializer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cabac_defines
// Description : Shared word-type codes, FSM states and word helpers for the
//               SAO bin serializer.
// Revision    : 1.0 - initial release
// ============================================================================
package cabac_defines;

    localparam logic [1:0] BIN_REG      = 2'b00;
    localparam logic [1:0] BIN_EMPTY    = 2'b01;
    localparam logic [1:0] BIN_BYP      = 2'b10;
    localparam int         MAX_BYP_BINS = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EMIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic       bypass;
        logic       val;
        logic [7:0] ctx;
    } bin_t;

    function automatic logic [2:0] byp_count(input logic [10:0] w);
        byp_count = (w[7:5] > 3'(MAX_BYP_BINS)) ? 3'(MAX_BYP_BINS) : w[7:5];
    endfunction

    // Reserved and zero-length bypass words carry no bins.
    function automatic logic word_nonempty(input logic [10:0] w);
        case (w[10:9])
            BIN_REG: word_nonempty = 1'b1;
            BIN_BYP: word_nonempty = (byp_count(w) != 3'd0);
            default: word_nonempty = 1'b0;
        endcase
    endfunction

    function automatic logic [2:0] init_cnt(input logic [10:0] w);
        init_cnt = (w[10:9] == BIN_BYP) ? byp_count(w) - 3'd1 : 3'd0;
    endfunction

    function automatic bin_t make_bin(input logic [10:0] w, input logic [2:0] cnt);
        bin_t b;
        if (w[10:9] == BIN_BYP) begin
            b.bypass = 1'b1;
            b.val    = w[cnt];
            b.ctx    = 8'd0;
        end else begin
            b.bypass = 1'b0;
            b.val    = w[8];
            b.ctx    = w[7:0];
        end
        return b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cabac_sao_bin_serializer_next_word.sv
`default_nettype none
// ============================================================================
// Module      : cabac_sao_next_word
// Description : Lowest set mask bit at or above the current index.
// Revision    : 1.0 - initial release
// ============================================================================
module cabac_sao_next_word #(
    parameter int NUM_WORDS = 8,
    parameter int IDX_W     = $clog2(NUM_WORDS)
) (
    input  logic [NUM_WORDS-1:0] i_mask,
    input  logic [IDX_W-1:0]     i_cur,
    output logic [IDX_W-1:0]     o_next,
    output logic                 o_none
);

    // Descending scan: the last hit written is the lowest qualifying index.
    always_comb begin
        o_next = '0;
        o_none = 1'b1;
        for (int i = NUM_WORDS - 1; i >= 0; i--) begin
            if (i_mask[i] && (i >= int'(i_cur))) begin
                o_next = IDX_W'(i);
                o_none = 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/cabac_sao_bin_serializer.sv
`default_nettype none
// ============================================================================
// Module      : cabac_sao_bin_serializer
// Description : Captures eight SAO binarization words and emits one bin per
//               valid/ready handshake to the BAC engine, skipping empty words.
// Revision    : 1.0 - initial release
// ============================================================================
module cabac_sao_bin_serializer
    import cabac_defines::*;
#(
    parameter int WORD_W    = 11,
    parameter int NUM_WORDS = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [WORD_W-1:0] word_0_i,
    input  logic [WORD_W-1:0] word_1_i,
    input  logic [WORD_W-1:0] word_2_i,
    input  logic [WORD_W-1:0] word_3_i,
    input  logic [WORD_W-1:0] word_4_i,
    input  logic [WORD_W-1:0] word_5_i,
    input  logic [WORD_W-1:0] word_6_i,
    input  logic [WORD_W-1:0] word_7_i,
    output logic              bin_valid_o,
    input  logic              bin_ready_i,
    output logic              bin_bypass_o,
    output logic              bin_val_o,
    output logic [7:0]        bin_ctx_o,
    output logic              busy_o,
    output logic              done_o
);

    localparam int c_IDX_W = $clog2(NUM_WORDS);

    logic [WORD_W-1:0]    w_in_words [NUM_WORDS];
    logic [WORD_W-1:0]    r_words    [NUM_WORDS];
    logic [NUM_WORDS-1:0] w_in_mask, r_mask, w_mask_nxt;
    logic [NUM_WORDS-1:0] w_enc_mask;
    logic [c_IDX_W-1:0]   w_enc_cur, w_enc_next, r_idx, w_idx_nxt;
    logic                 w_enc_none, w_capture;
    logic [2:0]           r_cnt, w_cnt_nxt, w_sel_cnt;
    logic [WORD_W-1:0]    w_sel_word;
    state_t               r_state, w_state_nxt;
    bin_t                 r_bin, w_bin_nxt;

    assign w_in_words[0] = word_0_i;
    assign w_in_words[1] = word_1_i;
    assign w_in_words[2] = word_2_i;
    assign w_in_words[3] = word_3_i;
    assign w_in_words[4] = word_4_i;
    assign w_in_words[5] = word_5_i;
    assign w_in_words[6] = word_6_i;
    assign w_in_words[7] = word_7_i;

    always_comb begin
        w_in_mask = '0;
        for (int i = 0; i < NUM_WORDS; i++) begin
            w_in_mask[i] = word_nonempty(w_in_words[i]);
        end
    end

    // In EMIT the current bit is pre-cleared, so an inclusive search from the
    // current index finds the following word; IDLE searches the fresh mask.
    always_comb begin
        if (r_state == ST_IDLE) begin
            w_enc_mask = w_in_mask;
            w_enc_cur  = '0;
        end else begin
            w_enc_mask = r_mask & ~(NUM_WORDS'(1) << r_idx);
            w_enc_cur  = r_idx;
        end
    end

    cabac_sao_next_word #(
        .NUM_WORDS (NUM_WORDS),
        .IDX_W     (c_IDX_W)
    ) u_next_word (
        .i_mask (w_enc_mask),
        .i_cur  (w_enc_cur),
        .o_next (w_enc_next),
        .o_none (w_enc_none)
    );

    assign w_sel_word = (r_state == ST_IDLE) ? w_in_words[w_enc_next] : r_words[w_enc_next];
    assign w_sel_cnt  = init_cnt(w_sel_word);

    always_comb begin
        w_state_nxt = r_state;
        w_mask_nxt  = r_mask;
        w_idx_nxt   = r_idx;
        w_cnt_nxt   = r_cnt;
        w_bin_nxt   = r_bin;
        w_capture   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start_i) begin
                    w_capture  = 1'b1;
                    w_mask_nxt = w_in_mask;
                    if (w_enc_none) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_state_nxt = ST_EMIT;
                        w_idx_nxt   = w_enc_next;
                        w_cnt_nxt   = w_sel_cnt;
                        w_bin_nxt   = make_bin(w_sel_word, w_sel_cnt);
                    end
                end
            end
            ST_EMIT: begin
                if (bin_ready_i) begin
                    if (r_cnt != 3'd0) begin
                        w_cnt_nxt = r_cnt - 3'd1;
                        w_bin_nxt = make_bin(r_words[r_idx], r_cnt - 3'd1);
                    end else begin
                        w_mask_nxt = w_enc_mask;
                        if (w_enc_none) begin
                            w_state_nxt = ST_DONE;
                        end else begin
                            w_idx_nxt = w_enc_next;
                            w_cnt_nxt = w_sel_cnt;
                            w_bin_nxt = make_bin(w_sel_word, w_sel_cnt);
                        end
                    end
                end
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mask <= '0;
            r_idx  <= '0;
            r_cnt  <= '0;
            r_bin  <= '0;
        end else begin
            r_mask <= w_mask_nxt;
            r_idx  <= w_idx_nxt;
            r_cnt  <= w_cnt_nxt;
            r_bin  <= w_bin_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (w_capture) begin
            for (int i = 0; i < NUM_WORDS; i++) begin
                r_words[i] <= w_in_words[i];
            end
        end
    end

    assign bin_valid_o  = (r_state == ST_EMIT);
    assign busy_o       = (r_state != ST_IDLE);
    assign done_o       = (r_state == ST_DONE);
    assign bin_bypass_o = r_bin.bypass;
    assign bin_val_o    = r_bin.val;
    assign bin_ctx_o    = r_bin.ctx;

endmodule
`default_nettype wire
